// File: rtl/sram_mem_controller.sv
// -----------------------------------------------------------------------------
// sram_mem_controller
//
// Sequences a 16-bit-wide, wait-stated external SRAM on behalf of the MEM
// pipeline stage. Each 32-bit word request becomes two halfword accesses:
// HI (data[31:16]) at the even halfword address, then LO (data[15:0]) at the
// odd one. ready drops while a transfer is in flight so the pipeline freezes.
// It rises again for the single DONE cycle, when the pipeline advances.
//
// Parameters
//   BASE_ADDR    byte address mapped to SRAM halfword 0
//   WAIT_CYCLES  cycles each halfword access is held (2..15)
//   SRAM_AW      SRAM halfword address width
//
// Ports
//   clk, rst     system clock (rising edge), asynchronous active-high reset
//   rd_en/wr_en  word read/write request, held stable while ready=0
//   address      byte address of the word
//   wdata        write data
//   rdata        read data, valid in DONE and held until the next read
//   ready        1 = no transfer pending or transfer completing this cycle
//   sram_addr    SRAM halfword address (registered)
//   sram_dq_out  data driven toward the SRAM (registered)
//   sram_dq_in   data returned from the SRAM
//   sram_dq_oe   1 = controller drives the DQ bus (registered)
//   sram_we_n    SRAM write strobe, active low (registered)
// -----------------------------------------------------------------------------
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Word index inside the SRAM: one bit narrower than the halfword address,
  // the halfword select bit is appended per phase.
  localparam int unsigned IW = SRAM_AW - 1;

  // Last cycle of a phase; the counter never needs more than 4 bits.
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic [3:0]    cnt_inc;
  logic          op_read;
  logic          req;
  logic [IW-1:0] word_idx;
  logic [SRAM_AW-1:0] hi_addr;
  logic [SRAM_AW-1:0] lo_addr;

  assign req     = rd_en | wr_en;
  assign cnt_inc = cnt + 4'd1;

  // Rebase the byte address (32-bit wrap), drop the byte offset and truncate
  // to the SRAM's word space in one step.
  assign word_idx = IW'((address - 32'(BASE_ADDR)) >> 2);
  assign hi_addr  = {word_idx, 1'b0};
  assign lo_addr  = {word_idx, 1'b1};

  // NOTE: ready is deliberately combinational so the very cycle a request
  // appears in IDLE already freezes the pipeline; a registered ready would
  // let the MEM stage advance one cycle too early.
  assign ready = ~req | (state == DONE);

  // NOTE: every register here, including rdata and the SRAM pin registers,
  // is cleared by the async reset so the strobes drop the instant rst rises;
  // all updates use non-blocking assignments so the registered outputs for
  // the next cycle are computed from this cycle's state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_read     <= 1'b0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // A simultaneous read and write is treated as a read.
            state       <= HI;
            cnt         <= '0;
            op_read     <= rd_en;
            sram_addr   <= hi_addr;
            sram_dq_out <= wdata[31:16];
            sram_dq_oe  <= ~rd_en;
            // WAIT_CYCLES >= 2, so cycle 0 of a write phase is never the last.
            sram_we_n   <= rd_en;
          end
        end

        HI: begin
          if (cnt == LAST) begin
            if (op_read) begin
              rdata[31:16] <= sram_dq_in;
            end
            state       <= LO;
            cnt         <= '0;
            sram_addr   <= lo_addr;
            sram_dq_out <= wdata[15:0];
            sram_we_n   <= op_read;
          end else begin
            cnt       <= cnt_inc;
            // Release the strobe for the final cycle of the phase: the rising
            // edge commits the halfword while address and data are stable.
            sram_we_n <= op_read | (cnt_inc == LAST);
          end
        end

        LO: begin
          if (cnt == LAST) begin
            if (op_read) begin
              rdata[15:0] <= sram_dq_in;
            end
            state      <= DONE;
            cnt        <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt       <= cnt_inc;
            sram_we_n <= op_read | (cnt_inc == LAST);
          end
        end

        DONE: begin
          // The pipeline advances at the end of this cycle; any new request
          // is first considered in the following IDLE cycle.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_controller
//
// Drives word requests into two controller instances (WAIT_CYCLES=2 and 4)
// attached to a behavioural halfword SRAM. Expected read data, latency and
// halfword writes are queued when a request is issued and compared when the
// controller completes the transfer or pulses its write strobe.
// -----------------------------------------------------------------------------
module tb_sram_mem_controller;

  localparam int W  = 2;
  localparam int W4 = 4;

  logic        clk = 1'b0;
  logic        rst;

  logic        rd_en, wr_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        rd4, wr4;
  logic [31:0] addr4, wdata4, rdata4;
  logic        ready4;
  logic [17:0] sram_addr4;
  logic [15:0] dq_out4, dq_in4;
  logic        dq_oe4, we_n4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W4), .SRAM_AW(18)) dut4 (
    .clk(clk), .rst(rst), .rd_en(rd4), .wr_en(wr4), .address(addr4),
    .wdata(wdata4), .rdata(rdata4), .ready(ready4), .sram_addr(sram_addr4),
    .sram_dq_out(dq_out4), .sram_dq_in(dq_in4),
    .sram_dq_oe(dq_oe4), .sram_we_n(we_n4)
  );

  // Behavioural SRAMs: a small array for the main instance, a fixed
  // address-derived pattern for the WAIT_CYCLES=4 instance.
  logic [15:0] mem [64];
  assign sram_dq_in = mem[sram_addr[5:0]];
  assign dq_in4     = sram_addr4[15:0] ^ 16'hA5A5;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } rd_exp_t;

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_exp_t;

  rd_exp_t rd_q[$];
  wr_exp_t wr_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write-strobe monitor: every rising edge of we_n while the bus is driven
  // commits one halfword, which must match the oldest queued expectation.
  time     t_fall;
  wr_exp_t w_exp;

  always @(negedge sram_we_n) t_fall = $time;

  always @(posedge sram_we_n) begin
    if (sram_dq_oe && !rst) begin
      if (wr_q.size() == 0) begin
        check("spurious_we", 32'd1, 32'd0);
      end else begin
        w_exp = wr_q.pop_front();
        check("we_addr", 32'(sram_addr), 32'(w_exp.addr));
        check("we_data", 32'(sram_dq_out), 32'(w_exp.data));
        check("we_width", 32'(($time - t_fall) / 10), 32'(W - 1));
      end
      mem[sram_addr[5:0]] = sram_dq_out;
    end
  end

  // Issue one word request at the current (post-negedge) time and follow it
  // to DONE. from_done: called while the previous transfer sits in DONE, so
  // the controller first sees the request one cycle later. chain_next: leave
  // the request asserted in DONE so the caller can chain another transfer.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rdata,
                      input bit from_done, input bit chain_next);
    logic [16:0] idx;
    int          low;
    rd_exp_t     r;
    idx = 17'((addr - 32'd1024) >> 2);
    rd_q.push_back('{exp_rdata, 1 + 2 * W});
    if (wr && !rd) begin
      wr_q.push_back('{{idx, 1'b0}, wd[31:16]});
      wr_q.push_back('{{idx, 1'b1}, wd[15:0]});
    end
    rd_en   = rd;
    wr_en   = wr;
    address = addr;
    wdata   = wd;
    #1;
    if (from_done) begin
      check("done_ready", 32'(ready), 32'd1);
      @(negedge clk);
      #1;
    end
    low = 0;
    while (!ready && low < 40) begin
      low++;
      @(negedge clk);
      #1;
    end
    r = rd_q.pop_front();
    check("latency", 32'(low), 32'(r.lat));
    check("rdata", rdata, r.rdata);
    if (!chain_next) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
      @(negedge clk);
      #1;
      check("idle_ready", 32'(ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int low4, n4, n5;
    rst = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;
    rd4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_out", 32'(sram_dq_out), 32'd0);
    check("rst_ready4", 32'(ready4), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Writes leave rdata holding its last read value.
    xfer(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    xfer(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    xfer(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1'b0);
    xfer(1'b0, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0);
    // Unaligned byte address maps to the same word.
    xfer(1'b1, 1'b0, 32'd1035, 32'h0, 32'h12345678, 1'b0, 1'b0);
    // Read wins over a simultaneous write; no strobe is queued.
    xfer(1'b1, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    // Back-to-back reads, second request set while the first is in DONE.
    xfer(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    xfer(1'b1, 1'b0, 32'd1028, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);

    // WAIT_CYCLES=4 instance: ready low 9 cycles, each halfword address
    // held 4 cycles; read data is the address-derived pattern.
    rd4   = 1'b1;
    addr4 = 32'd1032;
    #1;
    low4 = 0; n4 = 0; n5 = 0;
    while (!ready4 && low4 < 60) begin
      low4++;
      if (sram_addr4 == 18'd4) n4++;
      if (sram_addr4 == 18'd5) n5++;
      @(negedge clk);
      #1;
    end
    check("w4_latency", 32'(low4), 32'd9);
    check("w4_hold_hi", 32'(n4), 32'd4);
    check("w4_hold_lo", 32'(n5), 32'd4);
    check("w4_rdata", rdata4, 32'hA5A1A5A0);
    rd4 = 1'b0;
    @(negedge clk);
    #1;

    // Reset in the first cycle of a write's HI phase.
    wr_en   = 1'b1;
    address = 32'd1040;
    wdata   = 32'h11112222;
    @(posedge clk);
    #1;
    check("mid_we_n_low", 32'(sram_we_n), 32'd0);
    check("mid_oe_high", 32'(sram_dq_oe), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    check("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_addr", 32'(sram_addr), 32'd0);
    wr_en = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // A full-latency read afterwards shows the FSM restarted from IDLE.
    xfer(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences a 16-bit-wide, wait-stated external SRAM on behalf of the MEM pipeline stage.
- Accepts one 32-bit word read or write per request and splits it into two halfword accesses.
- Drives ready low while a transfer is in flight so hazard/freeze logic stalls the pipeline.
- Sits between the MEM stage request signals and the SRAM pins.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM halfword 0; subtracted from address before mapping.
- WAIT_CYCLES, 2: cycles each halfword access is held; legal range 2..15.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  word read request from MEM stage; held stable while ready=0.
- wr_en  input  1  word write request from MEM stage; held stable while ready=0.
- address  input  32  byte address of the word.
- wdata  input  32  write data.
- rdata  output  32  read data; valid in DONE and held until the next read completes.
- ready  output  1  high = no transfer pending or transfer completing this cycle; low = freeze pipeline.
- sram_addr  output  SRAM_AW  SRAM halfword address.
- sram_dq_out  output  16  data driven toward SRAM.
- sram_dq_in  input  16  data returned from SRAM.
- sram_dq_oe  output  1  1 = controller drives the DQ bus.
- sram_we_n  output  1  SRAM write strobe, active low.

Behaviour:
- Reset values (async on rst): state=IDLE, cnt=0, rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address map:
  - a = address - BASE_ADDR (32-bit, wraps); a[1:0] ignored.
  - Phase HI uses sram_addr = {a[SRAM_AW:2], 1'b0}; phase LO uses {a[SRAM_AW:2], 1'b1}.
  - Upper address bits are truncated.
  - Big-endian: HI halfword = data[31:16], LO = data[15:0].
- Priority: rd_en and wr_en both high → treated as a read; write is ignored.
- ready is combinational: ready = ~(rd_en | wr_en) | (state==DONE).
- FSM states: IDLE, HI, LO, DONE.
  - IDLE: if rd_en|wr_en, go to HI with cnt=0 and latch op (read/write); otherwise stay in IDLE.
  - HI: cnt increments each cycle. At cnt==WAIT_CYCLES-1:
    - read: rdata[31:16] <= sram_dq_in.
    - go to LO with cnt=0.
  - LO: same as HI. At the last cycle:
    - read: rdata[15:0] <= sram_dq_in.
    - go to DONE.
  - DONE: one cycle, then IDLE unconditionally. The pipeline advances at the end of DONE; a new request is first seen in the following IDLE cycle.
- Write phases:
  - sram_dq_oe=1 in HI and LO.
  - sram_dq_out carries the correct halfword.
  - sram_we_n=0 for cnt < WAIT_CYCLES-1 and 1 on the last cycle of each phase, giving a rising strobe edge per halfword.
- Read phases: sram_dq_oe=0, sram_we_n=1.
- IDLE and DONE: sram_dq_oe=0, sram_we_n=1.
- Latency: ready is low for 1+2*WAIT_CYCLES cycles (5 at default), then high for one cycle (DONE).
- Reset mid-transfer: FSM returns to IDLE immediately and strobes are deasserted. A partially written word is not rolled back; rdata is cleared.
- If the request drops while in HI or LO (protocol violation), the transfer still completes.

Test Plan:
- Reset: assert rst mid-write (HI, cnt=0) → sram_we_n=1 and sram_dq_oe=0 immediately; state=IDLE; rdata=0; ready=1 once the request is deasserted.
- Write then read: write address=1024, wdata=0xDEADBEEF.
  - Expected: sram_addr=0 with dq_out=0xDEAD, then sram_addr=1 with dq_out=0xBEEF; we_n low 1 cycle per phase; ready low 5 cycles.
  - Then read address=1024 → rdata=0xDEADBEEF in DONE.
- Address mapping: write address=1032, wdata=0x12345678 → sram_addr 4 and 5 receive 0x1234 and 0x5678. Read address=1035 (unaligned) → returns 0x12345678.
- Simultaneous rd_en=wr_en=1 at address=1024 holding 0xDEADBEEF, wdata=0 → no we_n pulse; rdata=0xDEADBEEF.
- Back-to-back reads of 1024 then 1028 (request updated at the end of DONE): second transfer starts in the following IDLE cycle; ready pattern is 0×5, 1, 0×5, 1.
- WAIT_CYCLES=4 build: single read → ready low 9 cycles; each sram_addr held 4 cycles.
